video_test_pattern_gen: RTL

//  AXI-Stream video source placed directly upstream of the frame/FPS monitor stage.

---
 rtl/video_test_pattern_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/video_test_pattern_gen.sv
// AXI-Stream video test pattern source: solid / ramp / checker frames emitted
// at a programmable frame period, with start-of-frame and end-of-line framing.
module video_test_pattern_gen #(
    parameter int IMG_WIDTH_MAX   = 16,
    parameter int IMG_HEIGHT_MAX  = 16,
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
    input  logic                       i_axi_clk,
    input  logic                       i_axi_rst,
    input  logic                       i_enable,
    input  logic [1:0]                 i_pattern_sel,
    input  logic [AXIS_DATA_WIDTH-1:0] i_solid_value,
    input  logic [IMG_WIDTH_MAX-1:0]   i_width,
    input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
    input  logic [31:0]                i_frame_interval,
    input  logic                       i_clear_overrun,
    output logic                       o_axis_out_tuser,
    output logic                       o_axis_out_tvalid,
    input  logic                       i_axis_out_tready,
    output logic                       o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] o_axis_out_tkeep,
    output logic                       o_busy,
    output logic [31:0]                o_frame_count,
    output logic                       o_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT} state_t;

    localparam logic [IMG_WIDTH_MAX-1:0]  W_ONE = 1;
    localparam logic [IMG_HEIGHT_MAX-1:0] H_ONE = 1;

    state_t                       state_q, state_d;
    logic [IMG_WIDTH_MAX-1:0]     x_q, x_d, width_q, width_d;
    logic [IMG_HEIGHT_MAX-1:0]    y_q, y_d, height_q, height_d;
    logic [1:0]                   pat_q, pat_d;
    logic [AXIS_DATA_WIDTH-1:0]   solid_q, solid_d, tdata_q, tdata_d;
    logic [31:0]                  timer_q, timer_d, frame_count_q, frame_count_d;
    logic                         pending_q, pending_d, overrun_q, overrun_d;
    logic                         tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic                         cfg_ok, accept, at_eol, last_beat, due, go, start, present;

    function automatic logic [AXIS_DATA_WIDTH-1:0] pixel(
        input logic [IMG_WIDTH_MAX-1:0]   x,
        input logic [IMG_HEIGHT_MAX-1:0]  y,
        input logic [1:0]                 pat,
        input logic [AXIS_DATA_WIDTH-1:0] solid
    );
        logic [31:0] xe;
        logic [31:0] ye;
        xe = 32'(x);
        ye = 32'(y);
        case (pat)
            2'd0:    return solid;
            2'd1:    return xe[AXIS_DATA_WIDTH-1:0];
            2'd2:    return ye[AXIS_DATA_WIDTH-1:0];
            default: return {AXIS_DATA_WIDTH{xe[3] ^ ye[3]}};
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        width_d       = width_q;
        height_d      = height_q;
        pat_d         = pat_q;
        solid_d       = solid_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        tvalid_d      = tvalid_q;
        tuser_d       = tuser_q;
        tlast_d       = tlast_q;
        tdata_d       = tdata_q;
        timer_d       = timer_q + 32'd1;
        start         = 1'b0;
        present       = 1'b0;

        cfg_ok    = (i_width != '0) && (i_height != '0);
        accept    = tvalid_q && i_axis_out_tready;
        at_eol    = (x_q == width_q - W_ONE);
        last_beat = at_eol && (y_q == height_q - H_ONE);
        due       = (i_frame_interval != '0) && (timer_q == i_frame_interval - 32'd1);
        // A missed due point is remembered so the late frame starts right after the current one.
        go        = (i_frame_interval == '0) || due || pending_q;

        if (i_clear_overrun) overrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                pending_d = 1'b0;
                start     = i_enable && cfg_ok;
            end
            S_ACTIVE: begin
                if (due && !(accept && last_beat)) begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
                if (accept) begin
                    if (!last_beat) begin
                        present = 1'b1;
                        if (at_eol) begin
                            x_d = '0;
                            y_d = y_q + H_ONE;
                        end else begin
                            x_d = x_q + W_ONE;
                        end
                    end else begin
                        frame_count_d = frame_count_q + 32'd1;
                        tvalid_d      = 1'b0;
                        tuser_d       = 1'b0;
                        tlast_d       = 1'b0;
                        if (!i_enable)         state_d = S_IDLE;
                        else if (go && cfg_ok) start   = 1'b1;
                        else                   state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (due) pending_d = 1'b1;
                if (!i_enable)         state_d = S_IDLE;
                else if (go && cfg_ok) start   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d   = S_ACTIVE;
            width_d   = i_width;
            height_d  = i_height;
            pat_d     = i_pattern_sel;
            solid_d   = i_solid_value;
            x_d       = '0;
            y_d       = '0;
            timer_d   = '0;
            pending_d = 1'b0;
            present   = 1'b1;
        end

        if (present) begin
            tvalid_d = 1'b1;
            tuser_d  = (x_d == '0) && (y_d == '0);
            tlast_d  = (x_d == width_d - W_ONE);
            tdata_d  = pixel(x_d, y_d, pat_d, solid_d);
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            width_q       <= '0;
            height_q      <= '0;
            pat_q         <= '0;
            solid_q       <= '0;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
            tvalid_q      <= 1'b0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            width_q       <= width_d;
            height_q      <= height_d;
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            tvalid_q      <= tvalid_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
        end
    end

    assign o_axis_out_tvalid = tvalid_q;
    assign o_axis_out_tuser  = tuser_q;
    assign o_axis_out_tlast  = tlast_q;
    assign o_axis_out_tdata  = tdata_q;
    assign o_axis_out_tkeep  = '1;
    assign o_busy            = (state_q == S_ACTIVE);
    assign o_frame_count     = frame_count_q;
    assign o_overrun         = overrun_q;

endmodule
